sponge_wrap_seq: RTL and testbench

Command sequencer that sits directly upstream of the SpongeWrap engine. It accepts one wrap or unwrap command with associated-data (AD) and body lengths, and streams RATE-bit words from a valid/ready input into the engine block by block, driving `start_continue`, `data_empty` and `last_block`. It collects engine output (ciphertext/plaintext and tag blocks) into a valid/ready output, checks the received tag on unwrap, and resets the engine between commands.

---
 rtl/sponge_wrap_seq.sv | 189 ++++++++++++++++++
 tb/tb_sponge_wrap_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sponge_wrap_seq.sv
// Command sequencer feeding a SpongeWrap engine: streams AD/body words in, collects result and tag words out.
// SPONGE_WRAP_SEQ_TAG_CHECK_EN: unwrap consumes and compares expected-tag words instead of emitting computed tags.
module sponge_wrap_seq #(
   parameter int unsigned RATE       = 16,
   parameter int unsigned TAG_BLOCKS = 4,
   parameter int unsigned LEN_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_start,
   input  logic             cmd_unwrap,
   input  logic [LEN_W-1:0] ad_len,
   input  logic [LEN_W-1:0] body_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RATE-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RATE-1:0]  out_data,
   output logic             out_tag,
   output logic             busy,
   output logic             done,
   output logic             tag_ok,
   output logic             wrap_rst,
   output logic             wrap_start_continue,
   output logic             wrap_unwrap,
   output logic             wrap_data_empty,
   output logic             wrap_last_block,
   output logic [RATE-1:0]  wrap_data_in,
   input  logic             wrap_busy,
   input  logic             wrap_data_out_ready,
   input  logic [RATE-1:0]  wrap_data_out
);

   localparam int unsigned TW = $clog2(TAG_BLOCKS + 1);

`ifdef SPONGE_WRAP_SEQ_TAG_CHECK_EN
   localparam bit TAG_CHECK = 1'b1;
`else
   localparam bit TAG_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CLEAR, S_DONE} state_t;
   typedef enum logic [1:0] {PH_AD, PH_BODY, PH_TAG} phase_t;

   state_t state, state_nx;
   phase_t phase;

   logic             unwrap_r;
   logic [LEN_W-1:0] ad_cnt, body_cnt, cur_cnt;
   logic [TW-1:0]    tag_cnt;
   logic [RATE-1:0]  hold_data;
   logic             hold_empty, hold_last;
   logic             mismatch, first_wait, tag_ok_r;
   logic             tag_in, tag_wrap, load_empty, in_hs, load_go;
   logic             capture, compare, wait_exit, phase_end, tag_ok_now;

   assign tag_in     = TAG_CHECK && unwrap_r;
   assign tag_wrap   = (phase == PH_TAG) && !tag_in;
   assign load_empty = (phase != PH_TAG) && (cur_cnt == '0);
   assign phase_end  = (cur_cnt <= LEN_W'(1));
   assign in_hs      = in_valid && in_ready;
   assign tag_ok_now = TAG_CHECK && unwrap_r && !mismatch;

   always_comb begin
      cur_cnt = '0;
      case (phase)
         PH_AD:   cur_cnt = ad_cnt;
         PH_BODY: cur_cnt = body_cnt;
         PH_TAG:  cur_cnt = LEN_W'(tag_cnt);
         default: cur_cnt = '0;
      endcase
   end

   always_comb begin
      state_nx            = state;
      in_ready            = 1'b0;
      load_go             = 1'b0;
      capture             = 1'b0;
      compare             = 1'b0;
      wait_exit           = 1'b0;
      wrap_start_continue = 1'b0;
      done                = 1'b0;
      tag_ok              = tag_ok_r;
      case (state)
         S_IDLE: if (cmd_start) state_nx = S_LOAD;
         S_LOAD: begin
            // Body and wrap-tag words wait for a free output register so no result can be dropped.
            in_ready = !load_empty && !tag_wrap && !((phase == PH_BODY) && out_valid);
            load_go  = load_empty || (in_valid && in_ready) || (tag_wrap && !out_valid);
            if (load_go) state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            wrap_start_continue = 1'b1;
            capture  = wrap_data_out_ready && (((phase == PH_BODY) && !hold_empty) || tag_wrap);
            compare  = wrap_data_out_ready && (phase == PH_TAG) && tag_in;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            wait_exit = !first_wait && !wrap_busy;
            if (wait_exit) state_nx = (phase_end && (phase == PH_TAG)) ? S_CLEAR : S_LOAD;
         end
         S_CLEAR: state_nx = S_DONE;
         S_DONE: begin
            done     = 1'b1;
            tag_ok   = tag_ok_now;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         phase      <= PH_AD;
         unwrap_r   <= 1'b0;
         ad_cnt     <= '0;
         body_cnt   <= '0;
         tag_cnt    <= '0;
         hold_data  <= '0;
         hold_empty <= 1'b0;
         hold_last  <= 1'b0;
         mismatch   <= 1'b0;
         first_wait <= 1'b0;
         tag_ok_r   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tag    <= 1'b0;
      end else begin
         state <= state_nx;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (capture) begin
            out_valid <= 1'b1;
            out_data  <= wrap_data_out;
            out_tag   <= (phase == PH_TAG);
         end
         case (state)
            S_IDLE: if (cmd_start) begin
               unwrap_r <= cmd_unwrap;
               ad_cnt   <= ad_len;
               body_cnt <= body_len;
               tag_cnt  <= TW'(TAG_BLOCKS);
               mismatch <= 1'b0;
               tag_ok_r <= 1'b0;
               phase    <= PH_AD;
            end
            S_LOAD: begin
               if (load_empty) begin
                  hold_data  <= '0;
                  hold_empty <= 1'b1;
                  hold_last  <= 1'b1;
               end else if (in_hs) begin
                  hold_data  <= in_data;
                  hold_empty <= 1'b0;
                  hold_last  <= (cur_cnt == LEN_W'(1));
               end
            end
            S_ISSUE: begin
               first_wait <= 1'b1;
               if (compare && ((wrap_data_out ^ hold_data) != '0)) mismatch <= 1'b1;
            end
            S_WAIT: begin
               first_wait <= 1'b0;
               if (wait_exit) begin
                  case (phase)
                     PH_AD:   if (ad_cnt != '0) ad_cnt <= ad_cnt - LEN_W'(1);
                     PH_BODY: if (body_cnt != '0) body_cnt <= body_cnt - LEN_W'(1);
                     default: if (tag_cnt != '0) tag_cnt <= tag_cnt - TW'(1);
                  endcase
                  // An empty AD/body phase still counts as one finished block.
                  if (phase_end && (phase == PH_AD)) phase <= PH_BODY;
                  if (phase_end && (phase == PH_BODY)) phase <= PH_TAG;
               end
            end
            S_DONE: tag_ok_r <= tag_ok_now;
            default: ;
         endcase
      end
   end

   assign busy            = (state != S_IDLE);
   assign wrap_rst        = reset || (state == S_CLEAR);
   assign wrap_unwrap     = unwrap_r;
   assign wrap_data_in    = hold_data;
   assign wrap_data_empty = hold_empty;
   assign wrap_last_block = hold_last;

endmodule

// File: tb/tb_sponge_wrap_seq.sv
// Bench for sponge_wrap_seq: behavioural engine stand-in, table-driven commands, scoreboard on the output stream.
module tb_sponge_wrap_seq;

   localparam int unsigned RATE = 16, TAG_BLOCKS = 4, LEN_W = 16;
`ifdef SPONGE_WRAP_SEQ_TAG_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk, reset, cmd_start, cmd_unwrap;
   logic [LEN_W-1:0] ad_len, body_len;
   logic in_valid, in_ready, out_valid, out_ready, out_tag, busy, done, tag_ok;
   logic [RATE-1:0] in_data, out_data, wrap_data_in, wrap_data_out;
   logic wrap_rst, wrap_start_continue, wrap_unwrap, wrap_data_empty, wrap_last_block;
   logic wrap_busy, wrap_data_out_ready;

   sponge_wrap_seq #(.RATE(RATE), .TAG_BLOCKS(TAG_BLOCKS), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_unwrap(cmd_unwrap),
      .ad_len(ad_len), .body_len(body_len), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .busy(busy), .done(done), .tag_ok(tag_ok), .wrap_rst(wrap_rst),
      .wrap_start_continue(wrap_start_continue), .wrap_unwrap(wrap_unwrap),
      .wrap_data_empty(wrap_data_empty), .wrap_last_block(wrap_last_block),
      .wrap_data_in(wrap_data_in), .wrap_busy(wrap_busy),
      .wrap_data_out_ready(wrap_data_out_ready), .wrap_data_out(wrap_data_out));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ks(input int unsigned i);
      logic [63:0] key;
      key = 64'h0011223344556677;
      return key[16*(i%4) +: 16] ^ 16'(i * 40503 + 7);
   endfunction
   function automatic logic [15:0] mix(input logic [15:0] acc, input logic [15:0] w);
      return {acc[14:0], acc[15]} ^ w ^ 16'h5A5A;
   endfunction
   function automatic logic [15:0] tagw(input logic [15:0] acc, input int unsigned i);
      return acc ^ ks(100 + i);
   endfunction

   // Engine stand-in: keystream XOR on body blocks, running absorb of AD/plaintext, tag words from the absorb state.
   logic [1:0] st_ph;
   logic [15:0] st_acc, st_pt;
   int unsigned st_blk, st_tidx;
   logic [3:0] st_bcnt;
   logic st_first;
   assign st_pt = wrap_unwrap ? (wrap_data_in ^ ks(st_blk)) : wrap_data_in;
   assign wrap_busy = (st_bcnt != 4'd0);
   assign wrap_data_out_ready = (st_ph != 2'd0);
   assign wrap_data_out = (st_ph == 2'd2) ? tagw(st_acc, st_tidx) : (wrap_data_in ^ ks(st_blk));

   always @(posedge clk) begin
      if (wrap_rst) begin
         st_ph <= 2'd0; st_acc <= '0; st_blk <= 0; st_tidx <= 0; st_bcnt <= '0; st_first <= 1'b1;
      end else begin
         if (st_bcnt != 4'd0) st_bcnt <= st_bcnt - 4'd1;
         if (wrap_start_continue) begin
            st_bcnt  <= st_first ? 4'd8 : 4'd3;
            st_first <= 1'b0;
            case (st_ph)
               2'd0: begin
                  if (!wrap_data_empty) st_acc <= mix(st_acc, wrap_data_in);
                  if (wrap_last_block) st_ph <= 2'd1;
               end
               2'd1: begin
                  if (!wrap_data_empty) begin
                     st_acc <= mix(st_acc, st_pt);
                     st_blk <= st_blk + 1;
                  end
                  if (wrap_last_block) st_ph <= 2'd2;
               end
               default: st_tidx <= st_tidx + 1;
            endcase
         end
      end
   end

   typedef struct packed { logic [15:0] data; logic tag; } exp_t;
   typedef struct {
      bit unwrap; int unsigned ad; int unsigned body; int unsigned seed;
      bit flip; bit poke; bit bp;
      bit exp_tag_ok; int unsigned exp_in_hs; int unsigned exp_out; int unsigned exp_empty;
   } vec_t;

   exp_t exp_q[$];
   exp_t e;
   logic [15:0] in_q[$];
   int n_checks, n_fail;
   int unsigned in_hs_cnt, out_cnt, done_cnt, empty_starts, starts_cnt;
   logic done_tag_ok;
   bit in_hs_q, hold_low, bp_en;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endfunction

   // Monitor: handshakes, scoreboard pops, done and engine-start bookkeeping.
   initial forever begin
      @(negedge clk);
      in_hs_q = in_valid && in_ready && !reset;
      if (!reset) begin
         if (in_hs_q) in_hs_cnt++;
         if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL out_unexpected: got data %h, required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_tag", 32'(out_tag), 32'(e.tag));
            end
         end
         if (done) begin done_cnt++; done_tag_ok = tag_ok; end
         if (wrap_start_continue) begin
            starts_cnt++;
            if (wrap_data_empty && wrap_last_block && st_ph != 2'd2) empty_starts++;
         end
      end
   end

   // Input stream and output back-pressure.
   initial begin
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (in_hs_q && in_q.size() != 0) void'(in_q.pop_front());
         in_valid = (in_q.size() != 0);
         if (in_valid) in_data = in_q[0]; else in_data = '0;
         out_ready = hold_low ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   task automatic launch(input vec_t v, input string nm);
      logic [15:0] acc, w, pt, t;
      acc = '0;
      in_q.delete(); exp_q.delete();
      in_hs_cnt = 0; out_cnt = 0; done_cnt = 0; empty_starts = 0; starts_cnt = 0; done_tag_ok = 1'bx;
      for (int unsigned i = 0; i < v.ad; i++) begin
         w = 16'hA000 ^ 16'(v.seed << 8) ^ 16'(i * 16'h0101);
         in_q.push_back(w);
         acc = mix(acc, w);
      end
      for (int unsigned i = 0; i < v.body; i++) begin
         pt = 16'h1234 ^ 16'(v.seed * 16'h0F0F) ^ 16'(i * 16'h1111);
         acc = mix(acc, pt);
         in_q.push_back(v.unwrap ? (pt ^ ks(i)) : pt);
         exp_q.push_back('{data: (v.unwrap ? pt : (pt ^ ks(i))), tag: 1'b0});
      end
      for (int unsigned i = 0; i < TAG_BLOCKS; i++) begin
         t = tagw(acc, i);
         if (v.unwrap && CHK) begin
            if (v.flip && i == 3) t = t ^ 16'h0001;
            in_q.push_back(t);
         end else exp_q.push_back('{data: t, tag: 1'b1});
      end
      bp_en = v.bp;
      @(negedge clk); #1;
      cmd_unwrap = v.unwrap; ad_len = LEN_W'(v.ad); body_len = LEN_W'(v.body); cmd_start = 1'b1;
      @(negedge clk); #1;
      cmd_start = 1'b0;
      chk({nm, "/busy_start"}, 32'(busy), 32'd1);
   endtask

   task automatic finish(input vec_t v, input string nm);
      for (int unsigned c = 0; c < 4000 && done_cnt == 0; c++) begin
         @(negedge clk); #1;
         if (v.poke && c == 12) begin
            chk({nm, "/poke_busy"}, 32'(busy), 32'd1);
            cmd_unwrap = ~v.unwrap; ad_len = 16'd7; body_len = 16'd9; cmd_start = 1'b1;
         end else cmd_start = 1'b0;
      end
      cmd_start = 1'b0;
      chk({nm, "/tag_ok_at_done"}, 32'(done_tag_ok), 32'(v.exp_tag_ok));
      for (int unsigned c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
      @(negedge clk); @(negedge clk); #1;
      chk({nm, "/done_pulses"}, done_cnt, 32'd1);
      chk({nm, "/busy_after"}, 32'(busy), 32'd0);
      chk({nm, "/tag_ok_held"}, 32'(tag_ok), 32'(v.exp_tag_ok));
      chk({nm, "/out_words"}, out_cnt, v.exp_out);
      chk({nm, "/out_pending"}, 32'(exp_q.size()), 32'd0);
      chk({nm, "/in_left"}, 32'(in_q.size()), 32'd0);
      chk({nm, "/in_handshakes"}, in_hs_cnt, v.exp_in_hs);
      chk({nm, "/empty_starts"}, empty_starts, v.exp_empty);
      chk({nm, "/out_valid_idle"}, 32'(out_valid), 32'd0);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "/busy"}, 32'(busy), 32'd0);
      chk({nm, "/done"}, 32'(done), 32'd0);
      chk({nm, "/tag_ok"}, 32'(tag_ok), 32'd0);
      chk({nm, "/in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, "/out_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "/out_data"}, 32'(out_data), 32'd0);
      chk({nm, "/out_tag"}, 32'(out_tag), 32'd0);
      chk({nm, "/start_continue"}, 32'(wrap_start_continue), 32'd0);
      chk({nm, "/wrap_data_in"}, 32'(wrap_data_in), 32'd0);
      chk({nm, "/data_empty"}, 32'(wrap_data_empty), 32'd0);
      chk({nm, "/last_block"}, 32'(wrap_last_block), 32'd0);
      chk({nm, "/wrap_rst"}, 32'(wrap_rst), 32'd1);
   endtask

   vec_t vecs[7];
   vec_t hv;
   int unsigned rdy_cnt, low_cnt;

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b1; cmd_start = 1'b0; cmd_unwrap = 1'b0; ad_len = '0; body_len = '0;
      hold_low = 1'b0; bp_en = 1'b0;
      in_hs_cnt = 0; out_cnt = 0; done_cnt = 0; empty_starts = 0; starts_cnt = 0;
      //          unw ad body seed flip poke bp  tag_ok  in_hs         out           empty
      vecs[0] = '{1'b0, 2, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0, 5,            7,            0};
      vecs[1] = '{1'b1, 2, 3, 1, 1'b0, 1'b0, 1'b0, CHK,  CHK ? 9 : 5,  CHK ? 3 : 7,  0};
      vecs[2] = '{1'b1, 2, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0, CHK ? 9 : 5,  CHK ? 3 : 7,  0};
      vecs[3] = '{1'b0, 0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0,            4,            2};
      vecs[4] = '{1'b0, 1, 5, 3, 1'b0, 1'b1, 1'b1, 1'b0, 6,            9,            0};
      vecs[5] = '{1'b1, 3, 1, 4, 1'b0, 1'b0, 1'b1, CHK,  CHK ? 8 : 4,  CHK ? 1 : 5,  0};
      vecs[6] = '{1'b1, 0, 0, 6, 1'b0, 1'b0, 1'b0, CHK,  CHK ? 4 : 0,  CHK ? 0 : 4,  2};

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         launch(vecs[i], $sformatf("vec%0d", i));
         finish(vecs[i], $sformatf("vec%0d", i));
      end

      // Output held off during the body: one word parks, no further input is accepted.
      hv = '{1'b0, 1, 4, 5, 1'b0, 1'b0, 1'b0, 1'b0, 5, 8, 0};
      hold_low = 1'b1;
      launch(hv, "hold");
      for (int unsigned c = 0; c < 500 && !out_valid; c++) @(negedge clk);
      rdy_cnt = 0; low_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (in_ready) rdy_cnt++;
         if (!out_valid) low_cnt++;
      end
      chk("hold/in_ready_cycles", rdy_cnt, 32'd0);
      chk("hold/out_valid_drops", low_cnt, 32'd0);
      chk("hold/in_handshakes", in_hs_cnt, 32'd2);
      chk("hold/out_words", out_cnt, 32'd0);
      hold_low = 1'b0;
      finish(hv, "hold");

      // Reset during the WAIT of body word 2, then a clean rerun.
      launch(vecs[0], "abort");
      for (int unsigned c = 0; c < 2000 && starts_cnt < 4; c++) begin @(negedge clk); #1; end
      @(negedge clk); #1;
      reset = 1'b1;
      @(negedge clk); #1;
      check_reset_vals("abort");
      repeat (2) @(negedge clk);
      #1;
      chk("abort/no_done", done_cnt, 32'd0);
      in_q.delete(); exp_q.delete();
      reset = 1'b0;
      launch(vecs[0], "rerun");
      finish(vecs[0], "rerun");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
